alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Parameter: OP_W, 5, ALU opcode width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  sequencer can accept a request.
REQ-007 Port: req_a  input  WIDTH  signed operand A.
REQ-008 Port: req_b  input  WIDTH  signed operand B.
REQ-009 Port: req_op  input  OP_W  opcode (0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOR).
REQ-010 Port: ALU_A  output  WIDTH  operand A driven to the external combinational ALU.
REQ-011 Port: ALU_B  output  WIDTH  operand B driven to the ALU.
REQ-012 Port: ALU_OP  output  OP_W  opcode driven to the ALU.
REQ-013 Port: ALU_OUT  input  WIDTH  combinational ALU result.
REQ-014 Port: rsp_valid  output  1  response present.
REQ-015 Port: rsp_ready  input  1  consumer accepts response.
REQ-016 Port: rsp_data  output  WIDTH  captured result.
REQ-017 Port: rsp_op  output  OP_W  opcode of the request that produced rsp_data.
REQ-018 Port: rsp_err  output  1  error flag qualifying rsp_data.

Function
REQ-019 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where state is IDLE and req_valid=1.
REQ-021 On acceptance, req_a, req_b, req_op SHALL be registered and state SHALL go to EXEC.
REQ-022 In EXEC, ALU_A/ALU_B SHALL present the registered operands and ALU_OP the registered opcode, or 0 if opcode > 6.
REQ-023 Outside EXEC, ALU_OP SHALL be 0 (NOP); ALU_A/ALU_B SHALL hold their last registered values.
REQ-024 At the edge ending EXEC, ALU_OUT SHALL be captured into rsp_data, the opcode into rsp_op, and state SHALL go to RESP; EXEC lasts exactly one cycle.
REQ-025 rsp_valid SHALL be 1 exactly while in RESP; latency from acceptance edge to rsp_valid=1 is 2 edges.
REQ-026 rsp_data, rsp_op, rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-027 On an edge with rsp_valid=1 and rsp_ready=1, state SHALL return to IDLE; a new request SHALL not be accepted on that same edge (min 3 cycles per op).
REQ-028 Opcode > 6 SHALL produce rsp_data=0 and rsp_err=1; legal opcodes SHALL produce rsp_err=0 unless REQ-032 applies.
REQ-029 req_valid changes while not in IDLE SHALL have no effect.

Reset
REQ-030 While rst=1: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_err=0, ALU_A=0, ALU_B=0, ALU_OP=0.
REQ-031 Reset asserted in EXEC or RESP SHALL abort the operation immediately; no response SHALL be produced for it.

Configuration
REQ-032 With ALU_SEQ_CHECK_EN defined, an internal model SHALL compute the expected result for legal opcodes and set rsp_err=1 when captured ALU_OUT differs (rsp_data still = ALU_OUT); without it, no model SHALL be built and rsp_err reflects only illegal opcodes.

Verification
REQ-033 Reset, then req a=5, b=7, op=1, rsp_ready=1 -> 2 edges later rsp_valid=1, rsp_data=12, rsp_op=1, rsp_err=0; IDLE next edge.
REQ-034 a=0x80000000, b=1, op=2 -> rsp_data=0x7FFFFFFF (wrap-around, no error).
REQ-035 op=9 -> ALU_OP=0 during EXEC, rsp_data=0, rsp_err=1.
REQ-036 op=6, a=0x0F0F0F0F, b=0xF0F0F0F0, rsp_ready=0 for 4 cycles -> rsp_data=0 held stable, req_ready=0 throughout, back-to-back req_valid ignored.
REQ-037 rst pulsed during EXEC -> rsp_valid never asserts for that request; req_ready=1 after reset.
REQ-038 With ALU_SEQ_CHECK_EN, ALU stub returning a+b+1 for op=1, a=2, b=2 -> rsp_data=5, rsp_err=1; without macro -> rsp_err=0.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Purpose:
//   Sequences single operations through an external combinational ALU.
//   A request (a, b, op) is accepted in IDLE and registered. During the one
//   EXEC cycle the registered operands and opcode drive the ALU. The ALU
//   result is captured at the end of EXEC and presented as a response until
//   the consumer accepts it. Opcodes above 6 are illegal: the ALU sees NOP
//   and the response carries data 0 with the error flag set.
//
// Optional feature (macro ALU_SEQ_CHECK_EN):
//   When ALU_SEQ_CHECK_EN is defined, an internal reference model recomputes
//   the result for ADD..NOR. rsp_err is raised if the captured ALU_OUT
//   disagrees with it; rsp_data still carries ALU_OUT. When undefined, no
//   model is built and rsp_err flags only illegal opcodes.
//
// Parameters:
//   WIDTH  operand / result width in bits
//   OP_W   opcode width in bits
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  sequencer can accept a request (IDLE only)
//   req_a      in   operand A
//   req_b      in   operand B
//   req_op     in   opcode (0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 NOR)
//   ALU_A      out  operand A to external ALU
//   ALU_B      out  operand B to external ALU
//   ALU_OP     out  opcode to external ALU (NOP outside EXEC / if illegal)
//   ALU_OUT    in   combinational ALU result
//   rsp_valid  out  response present (RESP only)
//   rsp_ready  in   consumer accepts response
//   rsp_data   out  captured result
//   rsp_op     out  opcode that produced rsp_data
//   rsp_err    out  error flag qualifying rsp_data
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [OP_W-1:0]  ALU_OP,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_err
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(6);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OP_W-1:0]  op_q;

  logic accept;
  logic capture;
  logic release_rsp;
  logic op_legal;
  logic mismatch;

  assign accept      = (state == IDLE) && req_valid;
  assign capture     = (state == EXEC);
  assign release_rsp = (state == RESP) && rsp_ready;
  assign op_legal    = (op_q <= OP_NOR);

  // State register. Reset aborts any operation in flight, so a request
  // interrupted in EXEC or RESP never produces a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. EXEC always lasts one cycle. Leaving RESP goes to IDLE
  // rather than straight to EXEC, so a request presented on the handshake
  // edge is not taken until the following edge.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)      state_next = EXEC;
      EXEC:                  state_next = RESP;
      RESP: if (release_rsp) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Request registers. These also feed ALU_A/ALU_B directly, so the ALU
  // operands keep their last accepted values outside EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op;
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] model_result;
  logic             model_valid;

  // Reference model of the external ALU. NOP has no defined result, so it
  // is never compared; illegal opcodes are flagged separately.
  always_comb begin
    model_result = '0;
    model_valid  = 1'b1;
    unique case (op_q)
      OP_ADD:  model_result = a_q + b_q;
      OP_SUB:  model_result = a_q - b_q;
      OP_AND:  model_result = a_q & b_q;
      OP_OR:   model_result = a_q | b_q;
      OP_XOR:  model_result = a_q ^ b_q;
      OP_NOR:  model_result = ~(a_q | b_q);
      default: model_valid  = 1'b0;
    endcase
  end

  assign mismatch = model_valid && (model_result != ALU_OUT);
`else
  assign mismatch = 1'b0;
`endif

  // Response registers. Loaded only at the end of EXEC, so they stay stable
  // for the whole RESP period regardless of how long the consumer stalls.
  // An illegal opcode reports zero data with the error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_op   <= '0;
      rsp_err  <= 1'b0;
    end else if (capture) begin
      rsp_op <= op_q;
      if (op_legal) begin
        rsp_data <= ALU_OUT;
        rsp_err  <= mismatch;
      end else begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_OP    = (capture && op_legal) ? op_q : OP_NOP;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Self-checking bench for alu_seq. A behavioural ALU stub answers the DUT's
// ALU port; it can be told to return a wrong ADD result. Expected responses
// are queued when a request is driven and popped when the DUT responds.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int WIDTH = 32;
  localparam int OP_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [OP_W-1:0]  req_op;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [OP_W-1:0]  ALU_OP;
  logic [WIDTH-1:0] ALU_OUT;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [OP_W-1:0]  rsp_op;
  logic             rsp_err;

  logic alu_fault = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
    int               hold;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [OP_W-1:0]  op;
    logic             err;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  alu_seq #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_OP    (ALU_OP),
    .ALU_OUT   (ALU_OUT),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_op    (rsp_op),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  // External combinational ALU stub; alu_fault corrupts ADD by +1.
  always_comb begin
    ALU_OUT = '0;
    case (ALU_OP)
      5'd1:    ALU_OUT = ALU_A + ALU_B + (alu_fault ? 32'd1 : 32'd0);
      5'd2:    ALU_OUT = ALU_A - ALU_B;
      5'd3:    ALU_OUT = ALU_A & ALU_B;
      5'd4:    ALU_OUT = ALU_A | ALU_B;
      5'd5:    ALU_OUT = ALU_A ^ ALU_B;
      5'd6:    ALU_OUT = ~(ALU_A | ALU_B);
      default: ALU_OUT = '0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops the oldest expected response and compares the DUT response to it.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_data", rsp_data, e.data);
      check("rsp_op",   rsp_op,   e.op);
      check("rsp_err",  rsp_err,  e.err);
    end
  endtask

  // Runs one full request/response transaction, stalling the consumer for
  // 'hold' cycles while issuing requests that must be ignored.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [OP_W-1:0] op, input logic [WIDTH-1:0] exp_data,
                               input logic exp_err, input int hold);
    logic [OP_W-1:0] exp_alu_op;
    int lat;
    exp_alu_op = (op <= 5'd6) ? op : 5'd0;

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    sb.push_back('{data: exp_data, op: op, err: exp_err});

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    req_op    = 5'd3;
    check("exec_alu_op",    ALU_OP,    exp_alu_op);
    check("exec_alu_a",     ALU_A,     a);
    check("exec_alu_b",     ALU_B,     b);
    check("exec_req_ready", req_ready, 0);
    check("exec_rsp_valid", rsp_valid, 0);

    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_latency", lat, 2);
    check("resp_alu_op", ALU_OP, 0);

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_a     = 32'h1111_1111;
      req_b     = 32'h2222_2222;
      req_op    = 5'd1;
      @(posedge clk);
      #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_req_ready", req_ready, 0);
      check("hold_rsp_data",  rsp_data,  exp_data);
      check("hold_alu_a",     ALU_A,     a);
    end

    rsp_ready = 1'b1;
    checkOutput();
    @(posedge clk);
    #1;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
    check("post_alu_op",    ALU_OP,    0);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic seen;
    logic exp_fault_err;

    vecs[0]  = '{32'd5,          32'd7,          5'd1, 32'd12,         1'b0, 0};
    vecs[1]  = '{32'h8000_0000,  32'd1,          5'd2, 32'h7FFF_FFFF,  1'b0, 0};
    vecs[2]  = '{32'h0000_00F0,  32'h0000_003C,  5'd3, 32'h0000_0030,  1'b0, 1};
    vecs[3]  = '{32'h0000_00F0,  32'h0000_000F,  5'd4, 32'h0000_00FF,  1'b0, 0};
    vecs[4]  = '{32'h0000_00FF,  32'h0000_000F,  5'd5, 32'h0000_00F0,  1'b0, 2};
    vecs[5]  = '{32'h0F0F_0F0F,  32'hF0F0_F0F0,  5'd6, 32'h0000_0000,  1'b0, 4};
    vecs[6]  = '{32'd3,          32'd4,          5'd9, 32'h0000_0000,  1'b1, 0};
    vecs[7]  = '{32'hFFFF_FFFF,  32'd1,          5'd1, 32'h0000_0000,  1'b0, 0};
    vecs[8]  = '{32'd3,          32'd5,          5'd2, 32'hFFFF_FFFE,  1'b0, 1};
    vecs[9]  = '{32'd1,          32'd1,          5'd7, 32'h0000_0000,  1'b1, 0};
    vecs[10] = '{32'h0000_0000,  32'h0000_0001,  5'd6, 32'hFFFF_FFFE,  1'b0, 0};
    vecs[11] = '{32'h1234_5678,  32'h0000_0001,  5'd31, 32'h0000_0000, 1'b1, 3};

    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    #12;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data",  rsp_data,  0);
    check("reset_rsp_op",    rsp_op,    0);
    check("reset_rsp_err",   rsp_err,   0);
    check("reset_alu_a",     ALU_A,     0);
    check("reset_alu_b",     ALU_B,     0);
    check("reset_alu_op",    ALU_OP,    0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_data, vecs[i].exp_err, vecs[i].hold);
    end

    // Faulty ALU result for ADD: only the checking build flags it.
`ifdef ALU_SEQ_CHECK_EN
    exp_fault_err = 1'b1;
`else
    exp_fault_err = 1'b0;
`endif
    alu_fault = 1'b1;
    applyStimulus(32'd2, 32'd2, 5'd1, 32'd5, exp_fault_err, 0);
    alu_fault = 1'b0;

    // Reset during EXEC aborts the request without a response.
    @(negedge clk);
    req_a     = 32'hABCD_0001;
    req_b     = 32'h0000_0002;
    req_op    = 5'd1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_exec_alu_op", ALU_OP, 1);
    rst = 1'b1;
    #2;
    check("abort_rst_req_ready", req_ready, 1);
    check("abort_rst_rsp_valid", rsp_valid, 0);
    check("abort_rst_alu_op",    ALU_OP,    0);
    check("abort_rst_alu_a",     ALU_A,     0);
    check("abort_rst_rsp_data",  rsp_data,  0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    check("abort_no_rsp",      seen,      0);
    check("abort_req_ready",   req_ready, 1);
    check("sb_drained",        sb.size(), 0);

    // Normal operation resumes after the aborted request.
    applyStimulus(32'd100, 32'd23, 5'd1, 32'd123, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
